// File: rtl/reg_file_2r1w_if.sv
// Operand/result bus of the two-read/one-write register file.
// The master drives addresses, write data and enables; the slave returns registered read data.
interface reg_file_2r1w_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4
);
  logic [AW-1:0]    Aaddr;
  logic [AW-1:0]    Baddr;
  logic [AW-1:0]    Caddr;
  logic [WIDTH-1:0] C;
  logic             Load;
  logic             RdEn;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Avalid;
  logic             Bvalid;

  modport master (
    output Aaddr, Baddr, Caddr, C, Load, RdEn,
    input  A, B, Avalid, Bvalid
  );

  modport slave (
    input  Aaddr, Baddr, Caddr, C, Load, RdEn,
    output A, B, Avalid, Bvalid
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with per-entry written flags, optional write-to-read
// bypass and optional hardwired-zero entry 0. Read ports are registered (one-cycle latency).
module reg_file_2r1w #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter bit          BYPASS   = 1'b0,
  parameter bit          ZERO_REG = 1'b0
) (
  input logic               Clk,
  input logic               Clear,
  reg_file_2r1w_if.slave    bus
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             av_q, av_d, bv_q, bv_d;
  logic             wr_en;

  // A write to entry 0 is dropped entirely when it is hardwired to zero.
  assign wr_en = bus.Load && !(ZERO_REG && (bus.Caddr == '0));

  always_comb begin
    mem_d  = mem_q;
    flag_d = flag_q;
    if (wr_en) begin
      mem_d[bus.Caddr]  = bus.C;
      flag_d[bus.Caddr] = 1'b1;
    end
  end

  always_comb begin
    a_d  = a_q;
    av_d = av_q;
    b_d  = b_q;
    bv_d = bv_q;
    if (bus.RdEn) begin
      if (ZERO_REG && (bus.Aaddr == '0)) begin
        a_d  = '0;
        av_d = 1'b1;
      end else if (BYPASS && wr_en && (bus.Aaddr == bus.Caddr)) begin
        a_d  = bus.C;
        av_d = 1'b1;
      end else begin
        a_d  = mem_q[bus.Aaddr];
        av_d = flag_q[bus.Aaddr];
      end

      if (ZERO_REG && (bus.Baddr == '0)) begin
        b_d  = '0;
        bv_d = 1'b1;
      end else if (BYPASS && wr_en && (bus.Baddr == bus.Caddr)) begin
        b_d  = bus.C;
        bv_d = 1'b1;
      end else begin
        b_d  = mem_q[bus.Baddr];
        bv_d = flag_q[bus.Baddr];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clear) begin
      mem_q  <= '{default: '0};
      flag_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      av_q   <= 1'b0;
      bv_q   <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      flag_q <= flag_d;
      a_q    <= a_d;
      b_q    <= b_d;
      av_q   <= av_d;
      bv_q   <= bv_d;
    end
  end

  assign bus.A      = a_q;
  assign bus.B      = b_q;
  assign bus.Avalid = av_q;
  assign bus.Bvalid = bv_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Drives four register-file configurations (BYPASS x ZERO_REG) with identical stimulus and
// compares each against a per-configuration reference model.
module tb_reg_file_2r1w;
  localparam int unsigned W = 16;
  localparam int unsigned D = 16;
  localparam int unsigned NCFG = 4;

  logic          Clk;
  logic          clear;
  logic          load;
  logic          rden;
  logic [3:0]    aaddr, baddr, caddr;
  logic [W-1:0]  cdata;

  logic [W-1:0]  a_o  [NCFG];
  logic [W-1:0]  b_o  [NCFG];
  logic          av_o [NCFG];
  logic          bv_o [NCFG];

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    reg_file_2r1w_if #(.WIDTH(W), .AW(4)) bus ();
    assign bus.Aaddr = aaddr;
    assign bus.Baddr = baddr;
    assign bus.Caddr = caddr;
    assign bus.C     = cdata;
    assign bus.Load  = load;
    assign bus.RdEn  = rden;
    assign a_o[g]  = bus.A;
    assign b_o[g]  = bus.B;
    assign av_o[g] = bus.Avalid;
    assign bv_o[g] = bus.Bvalid;

    reg_file_2r1w #(
      .WIDTH   (W),
      .DEPTH   (D),
      .BYPASS  ((g % 2) == 1),
      .ZERO_REG((g / 2) == 1)
    ) u_dut (
      .Clk  (Clk),
      .Clear(clear),
      .bus  (bus.slave)
    );
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: plain arrays updated once per rising edge from the behavioural rules.
  logic [W-1:0] m_mem  [NCFG][D];
  bit           m_flag [NCFG][D];
  logic [W-1:0] m_a [NCFG];
  logic [W-1:0] m_b [NCFG];
  bit           m_av [NCFG];
  bit           m_bv [NCFG];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_read(input int k, input int addr, input bit wr,
                            output logic [W-1:0] val, output bit vld);
    bit byp = (k % 2) == 1;
    bit zr  = (k / 2) == 1;
    if (zr && addr == 0) begin
      val = '0; vld = 1'b1;
    end else if (byp && wr && addr == int'(caddr)) begin
      val = cdata; vld = 1'b1;
    end else begin
      val = m_mem[k][addr]; vld = m_flag[k][addr];
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NCFG; k++) begin
      if (!clear) begin
        for (int i = 0; i < D; i++) begin
          m_mem[k][i] = '0;
          m_flag[k][i] = 1'b0;
        end
        m_a[k] = '0; m_b[k] = '0; m_av[k] = 1'b0; m_bv[k] = 1'b0;
      end else begin
        bit wr = load && !(((k / 2) == 1) && caddr == 4'd0);
        if (rden) begin
          model_read(k, int'(aaddr), wr, m_a[k], m_av[k]);
          model_read(k, int'(baddr), wr, m_b[k], m_bv[k]);
        end
        if (wr) begin
          m_mem[k][caddr] = cdata;
          m_flag[k][caddr] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input bit cl, input bit ld, input bit rd, input int aa, input int ba,
                       input int ca, input logic [W-1:0] cv);
    clear = cl; load = ld; rden = rd;
    aaddr = 4'(aa); baddr = 4'(ba); caddr = 4'(ca); cdata = cv;
  endtask

  // Inputs are driven after the falling edge; outputs sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge Clk);
    model_edge();
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("A[cfg%0d]", k), 32'(a_o[k]), 32'(m_a[k]));
      check($sformatf("B[cfg%0d]", k), 32'(b_o[k]), 32'(m_b[k]));
      check($sformatf("Avalid[cfg%0d]", k), 32'(av_o[k]), 32'(m_av[k]));
      check($sformatf("Bvalid[cfg%0d]", k), 32'(bv_o[k]), 32'(m_bv[k]));
    end
    @(negedge Clk);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, '0);
    @(negedge Clk);

    // Reset, then read never-written entries.
    cycle();
    drive(1'b1, 1'b0, 1'b1, 1, 2, 0, '0);
    cycle();
    check("reset_read_A", 32'(a_o[0]), 32'h0);
    check("reset_read_Avalid", 32'(av_o[0]), 32'h0);

    // Write then read with one-cycle latency.
    drive(1'b1, 1'b1, 1'b0, 0, 0, 3, 16'hFFFF);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 3, 4, 0, '0);
    cycle();
    check("wr_rd_A", 32'(a_o[0]), 32'hFFFF);
    check("wr_rd_Avalid", 32'(av_o[0]), 32'h1);
    check("wr_rd_Bvalid", 32'(bv_o[0]), 32'h0);

    // Read/write collision on entry 5.
    drive(1'b1, 1'b1, 1'b0, 0, 0, 5, 16'h0100);
    cycle();
    drive(1'b1, 1'b1, 1'b1, 5, 5, 5, 16'h0200);
    cycle();
    check("collide_nobyp_A", 32'(a_o[0]), 32'h0100);
    check("collide_byp_B", 32'(b_o[1]), 32'h0200);
    drive(1'b1, 1'b0, 1'b1, 5, 3, 0, '0);
    cycle();
    check("after_collide_A", 32'(a_o[0]), 32'h0200);

    // RdEn low: outputs hold while addresses change and writes occur.
    drive(1'b1, 1'b1, 1'b0, 9, 10, 3, 16'h5555);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1, 2, 5, 16'h7777);
    cycle();
    check("hold_A", 32'(a_o[0]), 32'h0200);

    // Clear with a pending write, then read back the whole file.
    for (int i = 0; i < int'(D); i++) begin
      drive(1'b1, 1'b1, 1'b0, 0, 0, i, 16'(16'h1000 + i));
      cycle();
    end
    drive(1'b0, 1'b1, 1'b1, 7, 7, 7, 16'h1234);
    cycle();
    for (int i = 0; i < int'(D); i += 2) begin
      drive(1'b1, 1'b0, 1'b1, i, i + 1, 0, '0);
      cycle();
    end
    drive(1'b1, 1'b0, 1'b1, 7, 7, 0, '0);
    cycle();
    check("clear_drops_write", 32'(a_o[0]), 32'h0);

    // Hardwired zero entry, with and without a same-cycle write.
    drive(1'b1, 1'b1, 1'b0, 0, 0, 0, 16'hABCD);
    cycle();
    drive(1'b1, 1'b0, 1'b1, 0, 0, 0, '0);
    cycle();
    check("zero_reg_A", 32'(a_o[2]), 32'h0);
    check("zero_reg_Avalid", 32'(av_o[2]), 32'h1);
    check("nozero_A", 32'(a_o[0]), 32'hABCD);
    drive(1'b1, 1'b1, 1'b1, 0, 0, 0, 16'h4321);
    cycle();
    check("zero_reg_byp_A", 32'(a_o[3]), 32'h0);

    // Randomized traffic with frequent address collisions.
    for (int n = 0; n < 800; n++) begin
      int ca = int'($urandom_range(0, D - 1));
      int aa = ($urandom_range(0, 3) == 0) ? ca : int'($urandom_range(0, D - 1));
      int ba = ($urandom_range(0, 3) == 0) ? ca : int'($urandom_range(0, D - 1));
      drive($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, aa, ba, ca, 16'($urandom()));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised two-read/one-write register file; next generation of the datapath register file.
- Generalised in data width and depth.
- Adds: separate read enable, per-entry written flags, selectable write-to-read bypass, optional hardwired-zero entry 0.
- Feeds the ALU A/B operand buses; the C result bus writes back into it.

Parameters:
- WIDTH, 16, data width of each entry and of A/B/C.
- DEPTH, 16, number of entries; power of two, at least 2.
- AW, log2(DEPTH) = 4, address width.
- BYPASS, 0: 0 = a read returns the pre-write value; 1 = a read returns C when its address equals the written address.
- ZERO_REG, 0: 1 = entry 0 always reads 0, writes to it are discarded, and it is always flagged valid.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Clear  input  1  synchronous active-low reset; clears all entries, flags and outputs.
- Aaddr  input  AW  read port A address.
- Baddr  input  AW  read port B address.
- Caddr  input  AW  write port address.
- C  input  WIDTH  write data.
- Load  input  1  write enable.
- RdEn  input  1  read enable; updates A/B/Avalid/Bvalid.
- A  output  WIDTH  registered read data, port A.
- B  output  WIDTH  registered read data, port B.
- Avalid  output  1  entry read on port A has been written since the last Clear.
- Bvalid  output  1  entry read on port B has been written since the last Clear.

Behaviour:
- Reset: Clear=0 sampled at a rising edge sets all DEPTH entries to 0, all written flags to 0, and A=B=0, Avalid=Bvalid=0.
  - Clear overrides Load and RdEn in the same cycle; nothing is written.
  - Clear asserted mid-stream discards the pending write, with no partial update.
  - Outputs are undefined before the first Clear edge; the bench must apply Clear first.
- Write: Clear=1 and Load=1 at the edge sets entry[Caddr]=C and flag[Caddr]=1.
  - Exception: ZERO_REG=1 and Caddr=0; the write is ignored.
- Read: Clear=1 and RdEn=1 at the edge loads A from entry[Aaddr] and B from entry[Baddr], with their flags into Avalid/Bvalid.
  - One-cycle latency: the value appears after the edge that sampled the address.
  - RdEn=0: A, B, Avalid, Bvalid hold their previous values.
- Load and RdEn are independent; both may be active in the same cycle.
- Read/write collision (RdEn=1, Load=1, read address == Caddr, write not discarded):
  - BYPASS=0: the port returns the old entry and old flag.
  - BYPASS=1: the port returns C with valid=1.
  - Applies to A and B independently; Aaddr==Baddr==Caddr forwards to both.
- ZERO_REG=1: a read of address 0 returns 0 with valid=1 regardless of writes or bypass.
- Addresses are full-range, with no wrap logic and no out-of-range case.
- No combinational path from inputs to outputs.

Test Plan:
1. Clear=0 for 1 edge, then RdEn=1 with Aaddr=1, Baddr=2 -> A=0, B=0, Avalid=Bvalid=0.
2. Load=1, Caddr=3, C=16'hFFFF; next cycle RdEn=1, Aaddr=3, Baddr=4 -> A=16'hFFFF, Avalid=1, B=0, Bvalid=0, all one edge after the read request.
3. Collision: entry 5 holds 16'h0100; same edge Load=1, Caddr=5, C=16'h0200, RdEn=1, Aaddr=Baddr=5.
   - BYPASS=0 -> A=B=16'h0100.
   - BYPASS=1 -> A=B=16'h0200.
   - Both settings: a following read returns 16'h0200.
4. RdEn=0 while Aaddr/Baddr change and writes occur -> A/B/Avalid/Bvalid unchanged from the prior read.
5. Clear=0 with Load=1, Caddr=7, C=16'h1234 in the same cycle -> entry 7 reads 0 and invalid afterwards; a fully written file reads back all zeros.
6. ZERO_REG=1: Load=1, Caddr=0, C=16'hABCD, then read Aaddr=0 -> A=0, Avalid=1. Repeat with BYPASS=1 in the same cycle -> A=0.
